// File: rtl/frame_buf_wr_if.sv
// Pixel stream, memory write port and reader handshake of the ping-pong frame buffer writer.
interface frame_buf_wr_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic                  pix_valid;
   logic                  pix_sof;
   logic [DATA_WIDTH-1:0] pix_data;
   logic                  pix_ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  frame_done;
   logic                  frame_avail;
   logic                  frame_buf;
   logic                  rd_release;
   logic                  sof_err;

   modport master (
      output pix_valid, pix_sof, pix_data, rd_release,
      input  pix_ready, wr_en, wr_addr, wr_data, frame_done, frame_avail, frame_buf, sof_err
   );

   modport slave (
      input  pix_valid, pix_sof, pix_data, rd_release,
      output pix_ready, wr_en, wr_addr, wr_data, frame_done, frame_avail, frame_buf, sof_err
   );
endinterface

// File: rtl/frame_buf_wr_ctrl.sv
// Write-side controller of a ping-pong frame buffer: turns a valid/ready pixel stream into
// memory writes and hands completed halves to the reader through an avail/release handshake.
module frame_buf_wr_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned FRAME_SIZE = 8
) (
   input  logic           clk,
   input  logic           reset,
   frame_buf_wr_if.slave  bus
);
   localparam int unsigned CNT_W = (FRAME_SIZE > 2) ? $clog2(FRAME_SIZE) : 1;
   localparam int unsigned LOW_W = ADDR_WIDTH - 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_SIZE - 1);

   typedef enum logic [1:0] {IDLE, WRITE, WAIT_BUF} state_t;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      pix_cnt, cnt_nx;
   logic                  wr_buf, wr_buf_nx;
   logic                  rd_buf, rd_buf_nx;
   logic [1:0]            buf_full, buf_full_nx, full_kept, full_set, rel_mask;
   logic                  ready_q, wr_en_q, done_q, avail_q, err_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q, addr_nx;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  wr_nx, done_nx, err_nx, avail_nx;
   logic                  accept, release_ok;

   assign accept     = bus.pix_valid & ready_q;
   assign release_ok = bus.rd_release & buf_full[rd_buf];

   // Release always frees the reader's half; the writer's half is never the one released.
   assign rel_mask    = release_ok ? (rd_buf ? 2'b10 : 2'b01) : 2'b00;
   assign full_kept   = buf_full & ~rel_mask;
   assign buf_full_nx = full_kept | full_set;
   assign rd_buf_nx   = rd_buf ^ release_ok;
   assign avail_nx    = buf_full_nx[rd_buf_nx];

   // Next-state, write address and pulse decode
   always_comb begin
      state_nx  = state;
      cnt_nx    = pix_cnt;
      wr_buf_nx = wr_buf;
      full_set  = 2'b00;
      wr_nx     = 1'b0;
      addr_nx   = wr_addr_q;
      done_nx   = 1'b0;
      err_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (accept && bus.pix_sof) begin
               wr_nx    = 1'b1;
               addr_nx  = {wr_buf, LOW_W'(0)};
               cnt_nx   = CNT_W'(1);
               state_nx = WRITE;
            end
         end
         WRITE: begin
            if (accept) begin
               wr_nx = 1'b1;
               if (bus.pix_sof) begin
                  addr_nx = {wr_buf, LOW_W'(0)};
                  cnt_nx  = CNT_W'(1);
                  err_nx  = 1'b1;
               end else begin
                  addr_nx = {wr_buf, LOW_W'(pix_cnt)};
                  if (pix_cnt == LAST) begin
                     full_set[wr_buf] = 1'b1;
                     done_nx          = 1'b1;
                     wr_buf_nx        = ~wr_buf;
                     cnt_nx           = '0;
                     state_nx         = full_kept[~wr_buf] ? WAIT_BUF : IDLE;
                  end else begin
                     cnt_nx = pix_cnt + CNT_W'(1);
                  end
               end
            end
         end
         WAIT_BUF: begin
            if (!buf_full[wr_buf]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pix_cnt   <= '0;
         wr_buf    <= 1'b0;
         rd_buf    <= 1'b0;
         buf_full  <= 2'b00;
         ready_q   <= 1'b1;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         avail_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nx;
         pix_cnt   <= cnt_nx;
         wr_buf    <= wr_buf_nx;
         rd_buf    <= rd_buf_nx;
         buf_full  <= buf_full_nx;
         ready_q   <= (state_nx != WAIT_BUF);
         wr_en_q   <= wr_nx;
         wr_addr_q <= addr_nx;
         if (wr_nx) wr_data_q <= bus.pix_data;
         done_q    <= done_nx;
         avail_q   <= avail_nx;
         err_q     <= err_nx;
      end
   end

   assign bus.pix_ready   = ready_q;
   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.frame_done  = done_q;
   assign bus.frame_avail = avail_q;
   assign bus.frame_buf   = rd_buf;
   assign bus.sof_err     = err_q;
endmodule

// File: tb/tb_frame_buf_wr_ctrl.sv
// Bench for frame_buf_wr_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_frame_buf_wr_ctrl;
   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 3;
   localparam int unsigned FS   = 4;
   localparam int unsigned HALF = 4;
   localparam int unsigned VW   = 2 + AW + DW + 4;
   localparam logic [VW-1:0] RST_VEC = {1'b1, 1'b0, AW'(0), DW'(0), 4'b0000};

   logic clk;
   logic reset;
   frame_buf_wr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   frame_buf_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_SIZE(FS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: mode 0 waiting for sof, 1 mid-frame, 2 blocked on a full half
   int              m_mode;
   int              m_cnt;
   bit              m_wbuf, m_rbuf;
   bit [1:0]        m_full;
   bit              m_ready, m_wen, m_done, m_err;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_data;
   logic [DW-1:0]   m_frame [FS];
   logic [DW-1:0]   exp_q [$];
   logic [DW-1:0]   mem [2*HALF];

   function automatic logic [VW-1:0] dut_vec();
      return {bus.pix_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
              bus.frame_done, bus.frame_avail, bus.frame_buf, bus.sof_err};
   endfunction

   function automatic logic [VW-1:0] model_vec();
      return {m_ready, m_wen, m_addr, m_data, m_done, m_full[m_rbuf], m_rbuf, m_err};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_wbuf = 0; m_rbuf = 0; m_full = 2'b00;
      m_ready = 1; m_wen = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_data = '0;
      exp_q.delete();
   endtask

   task automatic model_edge(input bit v, input bit s, input logic [DW-1:0] d, input bit rel);
      bit acc, rel_ok, wait_free;
      acc       = v && m_ready;
      rel_ok    = rel && m_full[m_rbuf];
      wait_free = !m_full[m_wbuf];
      m_wen = 0; m_done = 0; m_err = 0;
      if (rel_ok) begin
         m_full[m_rbuf] = 1'b0;
         m_rbuf = !m_rbuf;
         for (int i = 0; i < int'(FS); i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (m_mode == 2) begin
         if (wait_free) m_mode = 0;
      end else if (acc) begin
         if (s) begin
            m_err  = (m_mode == 1);
            m_mode = 1;
            m_cnt  = 0;
         end
         if (m_mode == 1) begin
            m_wen = 1;
            m_addr = AW'(int'(m_wbuf) * int'(HALF) + m_cnt);
            m_data = d;
            m_frame[m_cnt] = d;
            if (m_cnt == int'(FS) - 1) begin
               m_done = 1;
               m_full[m_wbuf] = 1'b1;
               for (int i = 0; i < int'(FS); i++) exp_q.push_back(m_frame[i]);
               m_wbuf = !m_wbuf;
               m_cnt  = 0;
               m_mode = m_full[m_wbuf] ? 2 : 0;
            end else begin
               m_cnt++;
            end
         end
      end
      m_ready = (m_mode != 2);
   endtask

   task automatic cycle(input bit v, input bit s, input logic [DW-1:0] d, input bit rel);
      bus.pix_valid  = v;
      bus.pix_sof    = s;
      bus.pix_data   = d;
      bus.rd_release = rel;
      model_edge(v, s, d, rel);
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) mem[bus.wr_addr] = bus.wr_data;
   endtask

   task automatic do_reset();
      bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_data = '0; bus.rd_release = 0;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_data = '0; bus.rd_release = 0;
      reset = 1'b1;
      model_reset();
      #3;
      total++;
      if (dut_vec() !== RST_VEC) begin
         bad++; $display("FAIL reset_values: got %h want %h", dut_vec(), RST_VEC);
      end
      @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, '0, 1);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec());
         end
      end
   endtask

   task automatic test_basic_frame();
      logic [DW-1:0] px [4] = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1, i == 0, px[i], 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL basic_beat%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      total++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_avail, bus.frame_buf}
          !== {1'b1, AW'(3), 16'h00A4, 1'b1, 1'b1, 1'b0}) begin
         bad++; $display("FAIL basic_last: got en=%b addr=%0d data=%h done=%b avail=%b buf=%b want 1 3 00a4 1 1 0",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_avail, bus.frame_buf);
      end
   endtask

   task automatic test_back_pressure();
      for (int i = 0; i < 4; i++) begin
         cycle(1, i == 0, DW'(16'h00B1 + i), 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL bp_frameb%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      cycle(1, 1, 16'h0EEE, 0);
      total++;
      if (bus.pix_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
         bad++; $display("FAIL bp_blocked: got ready=%b wr_en=%b want 0 0", bus.pix_ready, bus.wr_en);
      end
      cycle(0, 0, '0, 1);
      total++;
      if ({bus.frame_buf, bus.frame_avail, bus.pix_ready} !== 3'b110) begin
         bad++; $display("FAIL bp_release: got buf=%b avail=%b ready=%b want 1 1 0",
                         bus.frame_buf, bus.frame_avail, bus.pix_ready);
      end
      cycle(0, 0, '0, 0);
      total++;
      if (bus.pix_ready !== 1'b1) begin
         bad++; $display("FAIL bp_unblock: got ready=%b want 1", bus.pix_ready);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1, i == 0, DW'(16'h00C1 + i), 0);
         total++;
         if (bus.wr_addr !== AW'(i) || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL bp_third%0d: got %h (addr %0d) want %h (addr %0d)",
                            i, dut_vec(), bus.wr_addr, model_vec(), i);
         end
      end
   endtask

   task automatic test_drop_gaps();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, DW'(16'h0D00 + i), 0);
         total++;
         if (bus.wr_en !== 1'b0 || dut_vec() !== model_vec()) begin
            bad++; $display("FAIL drop_presof%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      for (int i = 0; i < 8; i++) begin
         cycle(i % 2 == 0, i == 0, DW'(16'h0E00 + i), 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL gap_cyc%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      total++;
      if ({bus.wr_en, bus.wr_addr, bus.frame_done} !== {1'b0, AW'(3), 1'b0} || mem[3] !== 16'h0E06) begin
         bad++; $display("FAIL gap_final: got en=%b addr=%0d done=%b mem3=%h want 0 3 0 0e06",
                         bus.wr_en, bus.wr_addr, bus.frame_done, mem[3]);
      end
   endtask

   task automatic test_resync();
      bit s [6] = '{1, 0, 1, 0, 0, 0};
      logic [DW-1:0] d [6] = '{16'h0C01, 16'h0C02, 16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1, s[i], d[i], 0);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL resync_beat%0d: got %h want %h", i, dut_vec(), model_vec());
         end
         if (i == 2) begin
            total++;
            if ({bus.sof_err, bus.wr_en, bus.wr_addr, bus.wr_data} !== {2'b11, AW'(0), 16'h0D01}) begin
               bad++; $display("FAIL resync_err: got err=%b en=%b addr=%0d data=%h want 1 1 0 0d01",
                               bus.sof_err, bus.wr_en, bus.wr_addr, bus.wr_data);
            end
         end
      end
      total++;
      if ({bus.frame_done, bus.wr_addr, bus.frame_avail} !== {1'b1, AW'(3), 1'b1}) begin
         bad++; $display("FAIL resync_done: got done=%b addr=%0d avail=%b want 1 3 1",
                         bus.frame_done, bus.wr_addr, bus.frame_avail);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1, i % 4 == 0, DW'(16'h0F00 + i), i == 7);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL simul_beat%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      total++;
      if ({bus.frame_done, bus.frame_buf, bus.frame_avail, bus.pix_ready, bus.wr_addr}
          !== {4'b1111, AW'(7)}) begin
         bad++; $display("FAIL simul_last: got done=%b buf=%b avail=%b ready=%b addr=%0d want 1 1 1 1 7",
                         bus.frame_done, bus.frame_buf, bus.frame_avail, bus.pix_ready, bus.wr_addr);
      end
      cycle(1, 1, 16'h0F10, 0);
      total++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(0)) begin
         bad++; $display("FAIL simul_next: got en=%b addr=%0d want 1 0", bus.wr_en, bus.wr_addr);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      cycle(1, 1, 16'h0101, 0);
      cycle(1, 0, 16'h0102, 0);
      total++;
      if (dut_vec() !== model_vec()) begin
         bad++; $display("FAIL midrst_pre: got %h want %h", dut_vec(), model_vec());
      end
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      total++;
      if (dut_vec() !== RST_VEC) begin
         bad++; $display("FAIL midrst_async: got %h want %h", dut_vec(), RST_VEC);
      end
      @(posedge clk); #1; reset = 1'b0;
      cycle(1, 1, 16'h0201, 0);
      total++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_buf} !== {1'b1, AW'(0), 16'h0201, 1'b0}) begin
         bad++; $display("FAIL midrst_restart: got en=%b addr=%0d data=%h buf=%b want 1 0 0201 0",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_buf);
      end
   endtask

   task automatic test_random();
      bit v, s, rel;
      logic [DW-1:0] d;
      int bad_idx;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         v   = ($urandom_range(0, 3) != 0);
         s   = ($urandom_range(0, 9) == 0);
         rel = ($urandom_range(0, 3) == 0);
         d   = DW'($urandom);
         if (rel && m_full[m_rbuf]) begin
            bad_idx = -1;
            for (int i = 0; i < int'(FS); i++)
               if (bad_idx < 0 && (exp_q.size() <= i || mem[int'(m_rbuf) * int'(HALF) + i] !== exp_q[i]))
                  bad_idx = i;
            total++;
            if (bad_idx >= 0) begin
               bad++;
               $display("FAIL rand_frame_data: half %0d word %0d got %h want %h", m_rbuf, bad_idx,
                        mem[int'(m_rbuf) * int'(HALF) + bad_idx],
                        (exp_q.size() > bad_idx) ? exp_q[bad_idx] : 'x);
            end
         end
         cycle(v, s, d, rel);
         total++;
         if (dut_vec() !== model_vec()) begin
            bad++; $display("FAIL rand_cyc%0d: got %h want %h", n, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_back_pressure();
      test_drop_gaps();
      test_resync();
      test_simultaneous();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
